// File: rtl/dm_lsu_hs.sv
// -----------------------------------------------------------------------------
// dm_lsu_hs -- data memory with sub-word load/store and a req/ready/rvalid
// handshake, for the MEM stage of a pipelined core.
//
// A request is accepted on a rising clk edge when req & ready. The access
// attributes are latched at that edge. After LATENCY wait cycles the access is
// performed, and rvalid pulses for exactly one cycle. The accept edge to
// rvalid high is LATENCY+1 cycles. ready stays low until the cycle after the
// rvalid pulse.
//
// Parameters
//   ADDR_W   word-address bits (depth = 2**ADDR_W words of 32 bits)
//   LATENCY  wait cycles between accept and response (0..2**CNT_W-1)
//   CNT_W    width of the wait-state counter
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset (also clears every RAM word)
//   req     in   access request
//   we      in   1 = store, 0 = load
//   size    in   00 byte, 01 half, 10 word, 11 illegal
//   sext    in   sign-extend sub-word loads when 1
//   addr    in   byte address; bits [ADDR_W+1:2] select the word (upper bits wrap)
//   wdata   in   store data (low byte/half/word used according to size)
//   pc      in   instruction PC, used only by the optional trace
//   ready   out  high only while idle and able to accept
//   rvalid  out  one-cycle response pulse
//   rdata   out  extended load data during rvalid; 0 otherwise and on stores
//   err     out  qualified by rvalid: misaligned access or size=11
//
// Optional feature: define DM_TRACE_EN to print a line for every committed
// store and for every misaligned or illegal access. Without the macro, the
// function is identical and no text is printed.
// -----------------------------------------------------------------------------
module dm_lsu_hs #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       pc_q, pc_d;
   logic              ready_q, ready_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic [31:0]       old_word;
   logic [31:0]       merged_word;
   logic [31:0]       load_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [3:0]        lane_en;
   logic              misalign;
   logic              mem_wen;

   // The access is always decoded from the latched request, never from the live inputs.
   assign idx      = addr_q[ADDR_W+1:2];
   assign old_word = mem_q[idx];

   always_comb begin
      misalign = 1'b0;
      lane_en  = 4'b0000;
      case (size_q)
         2'b00: lane_en = 4'b0001 << addr_q[1:0];
         2'b01: begin
            misalign = addr_q[0];
            lane_en  = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            misalign = (addr_q[1:0] != 2'b00);
            lane_en  = 4'b1111;
         end
         default: misalign = 1'b1;
      endcase
   end

   // Lane merge for read-modify-write. A byte store replicates wdata[7:0]
   // into any lane. A half store places wdata[15:0] on the chosen lane pair.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_wbyte;
         always_comb begin
            lane_wbyte = wdata_q[8*gi +: 8];
            if (size_q == 2'b00)
               lane_wbyte = wdata_q[7:0];
            else if (size_q == 2'b01)
               lane_wbyte = wdata_q[8*(gi%2) +: 8];
         end
         assign merged_word[8*gi +: 8] = lane_en[gi] ? lane_wbyte : old_word[8*gi +: 8];
      end
   endgenerate

   assign ld_byte = 8'(old_word >> {addr_q[1:0], 3'b000});
   assign ld_half = addr_q[1] ? old_word[31:16] : old_word[15:0];

   always_comb begin
      load_data = '0;
      case (size_q)
         2'b00:   load_data = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
         2'b01:   load_data = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
         2'b10:   load_data = old_word;
         default: load_data = '0;
      endcase
   end

   assign mem_wen = (state_q == S_RESP) && we_q && !misalign;

   // Handshake FSM
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      size_d   = size_q;
      sext_d   = sext_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      pc_d     = pc_q;
      ready_d  = ready_q;
      rvalid_d = 1'b0;
      rdata_d  = '0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // ready rises one cycle after the return to IDLE. This keeps it
            // low during the rvalid cycle.
            ready_d = 1'b1;
            if (req && ready_q) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               addr_d  = addr;
               wdata_d = wdata;
               pc_d    = pc;
               cnt_d   = LAT_C;
               ready_d = 1'b0;
               state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            ready_d = 1'b0;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q <= 1) state_d = S_RESP;
         end
         S_RESP: begin
            ready_d  = 1'b0;
            rvalid_d = 1'b1;
            err_d    = misalign;
            rdata_d  = (misalign || we_q) ? 32'h0 : load_data;
            state_d  = S_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         sext_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         pc_q     <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sext_q   <= sext_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         pc_q     <= pc_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // One register per word, so that reset can clear the whole array. A store
   // that is aborted by reset never reaches S_RESP, so it is never written.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [31:0] word_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               word_q <= '0;
            else if (mem_wen && (idx == ADDR_W'(gi)))
               word_q <= merged_word;
         end
         assign mem_q[gi] = word_q;
      end
   endgenerate

`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (reset && (state_q == S_RESP)) begin
         if (misalign)
            $display("@%h: DM misaligned %h", pc_q, addr_q);
         else if (we_q)
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged_word);
      end
   end
`endif

   // The upper address bits wrap, and pc is needed only by the trace.
   logic unused_bits;
   assign unused_bits = ^{pc_q, addr_q[31:ADDR_W+2]};

   assign ready  = ready_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign err    = err_q;

endmodule
